lcd_spi_scheduler: RTL and testbench

- Shares the single spi_master instance that drives the PCD8544 (Nokia 5110) LCD between two byte-stream requesters.
  - Requester 0: init/config sequencer.
  - Requester 1: sprite/pixel drawer.
- Arbitrates per burst and locks the grant until the requester's last byte has gone out.
- Feeds spi_master's data_in/command/start and paces bytes on spi_master's avail pulse.
- Runs a watchdog so a stalled SPI transfer cannot hang the display pipeline.

---
 rtl/lcd_spi_pkg.sv | 34 +++
 rtl/lcd_spi_scheduler_arb.sv | 23 ++
 rtl/lcd_spi_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_lcd_spi_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_pkg
// Description : Shared types and constants for the PCD8544 SPI scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_spi_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    // PCD8544 command bytes used by the init sequencer and drawer
    localparam logic [7:0] FUNC_EXT    = 8'h21;
    localparam logic [7:0] VOP         = 8'h90;
    localparam logic [7:0] FUNC_BASIC  = 8'h20;
    localparam logic [7:0] DISP_NORMAL = 8'h0C;
    localparam logic [7:0] SET_X       = 8'h80;
    localparam logic [7:0] SET_Y       = 8'h40;
    localparam int         FB_BYTES    = 504;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
    } beat_t;

    function automatic beat_t pick_beat(input logic [1:0] sel, input beat_t b0, input beat_t b1);
        return sel[1] ? b1 : b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_spi_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr2
// Description : Two-input round-robin / fixed-priority one-hot picker.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_served_i,
    input  logic       rr_mode_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = req_i;
        // On a tie, round-robin favours whoever was not served last
        if (req_i == 2'b11) begin
            win_o = (rr_mode_i && !last_served_i) ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_scheduler
// Description : Burst-locked arbiter sharing one spi_master between two LCD
//               byte-stream requesters, with a SEND watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_scheduler
    import lcd_spi_pkg::*;
#(
    parameter logic [15:0] DIV_FACTOR = 16'd25000,
    parameter logic [23:0] TIMEOUT    = 24'd1000000,
    parameter logic        RR_MODE    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        r0_valid_i,
    input  logic [7:0]  r0_data_i,
    input  logic        r0_dc_i,
    input  logic        r0_last_i,
    output logic        r0_ready_o,
    input  logic        r1_valid_i,
    input  logic [7:0]  r1_data_i,
    input  logic        r1_dc_i,
    input  logic        r1_last_i,
    output logic        r1_ready_o,
    output logic [7:0]  spi_data_o,
    output logic        spi_comm_o,
    output logic        spi_start_o,
    output logic [15:0] spi_div_o,
    input  logic        spi_avail_i,
    input  logic        spi_busy_i,
    output logic [1:0]  grant_o,
    output logic        idle_o,
    output logic        timeout_err_o
);

    logic [1:0]  state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        comm_q, comm_d;
    logic        start_q, start_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_flag_q, last_flag_d;
    logic        last_served_q, last_served_d;
    logic [23:0] wdog_q, wdog_d;
    logic        terr_q, terr_d;

    logic [1:0]  w_req;
    logic [1:0]  w_win;
    logic [1:0]  w_ready;
    beat_t       w_beat0;
    beat_t       w_beat1;
    beat_t       w_load_beat;

    assign w_req       = {r1_valid_i, r0_valid_i};
    assign w_beat0     = {r0_data_i, r0_dc_i, r0_last_i};
    assign w_beat1     = {r1_data_i, r1_dc_i, r1_last_i};
    assign w_load_beat = pick_beat(w_ready, w_beat0, w_beat1);

    arb_rr2 u_arb (
        .req_i         (w_req),
        .last_served_i (last_served_q),
        .rr_mode_i     (RR_MODE),
        .win_o         (w_win)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            data_q        <= 8'h00;
            comm_q        <= 1'b0;
            start_q       <= 1'b0;
            grant_q       <= 2'b00;
            last_flag_q   <= 1'b0;
            last_served_q <= 1'b1;
            wdog_q        <= 24'd0;
            terr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            comm_q        <= comm_d;
            start_q       <= start_d;
            grant_q       <= grant_d;
            last_flag_q   <= last_flag_d;
            last_served_q <= last_served_d;
            wdog_q        <= wdog_d;
            terr_q        <= terr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        comm_d        = comm_q;
        start_d       = start_q;
        grant_d       = grant_q;
        last_flag_d   = last_flag_q;
        last_served_d = last_served_q;
        wdog_d        = wdog_q;
        terr_d        = terr_q;

        case (state_q)
            IDLE: begin
                if (|w_ready) begin
                    data_d        = w_load_beat.data;
                    comm_d        = w_load_beat.dc;
                    last_flag_d   = w_load_beat.last;
                    grant_d       = w_ready;
                    last_served_d = w_ready[1];
                    start_d       = 1'b1;
                    wdog_d        = 24'd0;
                    state_d       = SEND;
                end
            end
            SEND: begin
                if (spi_avail_i) begin
                    wdog_d = 24'd0;
                    if (last_flag_q) begin
                        start_d = 1'b0;
                        state_d = DRAIN;
                    end else if (|w_ready) begin
                        data_d      = w_load_beat.data;
                        comm_d      = w_load_beat.dc;
                        last_flag_d = w_load_beat.last;
                    end else begin
                        start_d = 1'b0;
                        state_d = HOLD;
                    end
                end else if (wdog_q == TIMEOUT - 24'd1) begin
                    // Stalled transfer: drop the byte and release the bus
                    terr_d  = 1'b1;
                    start_d = 1'b0;
                    wdog_d  = 24'd0;
                    state_d = DRAIN;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
            HOLD: begin
                if (|w_ready) begin
                    data_d      = w_load_beat.data;
                    comm_d      = w_load_beat.dc;
                    last_flag_d = w_load_beat.last;
                    start_d     = 1'b1;
                    wdog_d      = 24'd0;
                    state_d     = SEND;
                end
            end
            DRAIN: begin
                if (!spi_busy_i) begin
                    grant_d = 2'b00;
                    wdog_d  = 24'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w_ready = 2'b00;
        case (state_q)
            IDLE:    w_ready = w_win;
            SEND:    if (spi_avail_i && !last_flag_q) w_ready = grant_q & w_req;
            HOLD:    w_ready = grant_q & w_req;
            default: w_ready = 2'b00;
        endcase
    end

    assign r0_ready_o    = w_ready[0] & rst_ni;
    assign r1_ready_o    = w_ready[1] & rst_ni;
    assign idle_o        = (state_q == IDLE);
    assign spi_data_o    = data_q;
    assign spi_comm_o    = comm_q;
    assign spi_start_o   = start_q;
    assign spi_div_o     = DIV_FACTOR;
    assign grant_o       = grant_q;
    assign timeout_err_o = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_scheduler
// Description : Scoreboard bench for lcd_spi_scheduler with an spi_master model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r0_valid = 1'b0, r0_dc = 1'b0, r0_last = 1'b0;
    logic [7:0]  r0_data = 8'h00;
    logic        r1_valid = 1'b0, r1_dc = 1'b0, r1_last = 1'b0;
    logic [7:0]  r1_data = 8'h00;
    logic        r0_ready, r1_ready;
    logic [7:0]  spi_data;
    logic        spi_comm, spi_start;
    logic [15:0] spi_div;
    logic        spi_avail = 1'b0, spi_busy = 1'b0;
    logic [1:0]  grant;
    logic        idle, timeout_err;

    // second instance: fixed priority
    logic        q_r0_valid = 1'b0, q_r1_valid = 1'b0, q_avail = 1'b0;
    logic        q_r0_ready, q_r1_ready, q_comm, q_start, q_idle, q_terr;
    logic [7:0]  q_data;
    logic [15:0] q_div;
    logic [1:0]  q_grant;

    lcd_spi_scheduler #(.DIV_FACTOR(16'd25000), .TIMEOUT(24'd100), .RR_MODE(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_valid_i(r0_valid), .r0_data_i(r0_data), .r0_dc_i(r0_dc), .r0_last_i(r0_last), .r0_ready_o(r0_ready),
        .r1_valid_i(r1_valid), .r1_data_i(r1_data), .r1_dc_i(r1_dc), .r1_last_i(r1_last), .r1_ready_o(r1_ready),
        .spi_data_o(spi_data), .spi_comm_o(spi_comm), .spi_start_o(spi_start), .spi_div_o(spi_div),
        .spi_avail_i(spi_avail), .spi_busy_i(spi_busy),
        .grant_o(grant), .idle_o(idle), .timeout_err_o(timeout_err)
    );

    lcd_spi_scheduler #(.DIV_FACTOR(16'd25000), .TIMEOUT(24'd100), .RR_MODE(1'b0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_valid_i(q_r0_valid), .r0_data_i(8'h21), .r0_dc_i(1'b0), .r0_last_i(1'b1), .r0_ready_o(q_r0_ready),
        .r1_valid_i(q_r1_valid), .r1_data_i(8'h42), .r1_dc_i(1'b1), .r1_last_i(1'b1), .r1_ready_o(q_r1_ready),
        .spi_data_o(q_data), .spi_comm_o(q_comm), .spi_start_o(q_start), .spi_div_o(q_div),
        .spi_avail_i(q_avail), .spi_busy_i(1'b0),
        .grant_o(q_grant), .idle_o(q_idle), .timeout_err_o(q_terr)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [10:0] exp_q[$];
    bit          spi_en = 1'b1;
    bit          abort_burst = 1'b0;
    int          rises = 0;
    int          r0_cnt = 0;
    bit          q_r1_seen = 1'b0;
    logic        prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic dc, input logic [7:0] d);
        exp_q.push_back({g, dc, d});
    endtask

    // spi_master model: avail every 8 start cycles, busy lingers 3 cycles
    initial begin
        int cnt = 0;
        int hold = 0;
        forever begin
            @(posedge clk);
            #1;
            spi_avail = 1'b0;
            if (!rst_n) begin
                cnt = 0; hold = 0; spi_busy = 1'b0;
            end else if (spi_start) begin
                spi_busy = 1'b1;
                hold = 3;
                if (spi_en) begin
                    cnt++;
                    if (cnt == 8) begin
                        spi_avail = 1'b1;
                        cnt = 0;
                    end
                end
            end else begin
                cnt = 0;
                if (hold > 0) hold--;
                else spi_busy = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (spi_start && !prev_start) rises++;
            if (r0_valid && r0_ready) r0_cnt++;
            if (q_r1_ready) q_r1_seen = 1'b1;
            if (r0_ready || r1_ready) begin
                check("ready_excl", {31'd0, r0_ready & r1_ready}, 32'd0);
                if (!idle) check("ready_owner", {30'd0, {r1_ready, r0_ready} & ~grant}, 32'd0);
            end
            if (spi_avail && spi_start) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h with no expected byte", {grant, spi_comm, spi_data});
                end else begin
                    check("sb_byte", {21'd0, grant, spi_comm, spi_data}, {21'd0, exp_q.pop_front()});
                end
            end
        end
        prev_start = spi_start;
    end

    task automatic drive(input int r, input logic v, input logic [7:0] d, input logic dc, input logic last);
        if (r == 0) begin
            r0_valid = v; r0_data = d; r0_dc = dc; r0_last = last;
        end else begin
            r1_valid = v; r1_data = d; r1_dc = dc; r1_last = last;
        end
    endtask

    task automatic burst(input int r, input int n, input logic [31:0] d, input logic [3:0] dc,
                         input int gap_after, input int gap);
        bit ok;
        int k;
        for (int i = 0; i < n; i++) begin
            if (abort_burst) break;
            drive(r, 1'b1, d[8*i +: 8], dc[i], (i == n - 1));
            ok = 1'b0;
            k = 0;
            while (!ok && !abort_burst && k < 400) begin
                @(negedge clk);
                ok = (r == 0) ? r0_ready : r1_ready;
                @(posedge clk);
                #1;
                k++;
            end
            if (!ok && !abort_burst) begin
                n_tests++;
                n_fail++;
                $display("FAIL burst_wait: r%0d byte %0d got ready 0 expected 1", r, i);
                break;
            end
            if (i == gap_after) begin
                drive(r, 1'b0, 8'h00, 1'b0, 1'b0);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        drive(r, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!idle && k < 300);
        check(name, {31'd0, idle}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        // reset state
        r0_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, spi_data}, 32'd0);
        check("rst_start", {31'd0, spi_start}, 32'd0);
        check("rst_comm", {31'd0, spi_comm}, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        check("rst_ready", {31'd0, r0_ready}, 32'd0);
        check("spi_div", {16'd0, spi_div}, 32'd25000);
        r0_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // init burst on r0
        rises = 0;
        r0_cnt = 0;
        push(2'b01, 1'b0, 8'h21); push(2'b01, 1'b0, 8'h90);
        push(2'b01, 1'b0, 8'h20); push(2'b01, 1'b0, 8'h0C);
        burst(0, 4, 32'h0C209021, 4'b0000, -1, 0);
        wait_idle("t1_idle");
        check("t1_start_rises", rises, 32'd1);
        check("t1_r0_ready_cnt", r0_cnt, 32'd4);
        check("t1_grant_clear", {30'd0, grant}, 32'd0);
        check("t1_sb_empty", exp_q.size(), 32'd0);

        // round-robin contention, twice
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            push(2'b01, 1'b0, 8'h80); push(2'b01, 1'b0, 8'h40);
            push(2'b10, 1'b1, 8'hAA); push(2'b10, 1'b1, 8'h55);
            fork
                burst(0, 2, 32'h00004080, 4'b0000, -1, 0);
                burst(1, 2, 32'h000055AA, 4'b0011, -1, 0);
            join
            wait_idle("t2_idle");
            check("t2_sb_empty", exp_q.size(), 32'd0);
        end

        // HOLD with the other requester knocking
        push(2'b10, 1'b0, 8'hA8); push(2'b10, 1'b0, 8'h42); push(2'b10, 1'b1, 8'h1F);
        fork
            burst(1, 3, 32'h001F42A8, 4'b0100, 1, 16);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!(spi_avail && spi_data == 8'h42) && k < 100);
                @(negedge clk);
                check("t3_hold_start", {31'd0, spi_start}, 32'd0);
                check("t3_hold_grant", {30'd0, grant}, 32'd2);
                check("t3_hold_idle", {31'd0, idle}, 32'd0);
                @(posedge clk);
                #1;
                drive(0, 1'b1, 8'h99, 1'b0, 1'b1);
                repeat (3) begin
                    @(negedge clk);
                    check("t3_hold_r0_ready", {31'd0, r0_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                push(2'b01, 1'b0, 8'h99);
                burst(0, 1, 32'h00000099, 4'b0000, -1, 0);
            end
        join
        wait_idle("t3_idle");
        check("t3_sb_empty", exp_q.size(), 32'd0);

        // watchdog: no avail at all
        spi_en = 1'b0;
        burst(0, 1, 32'h00000055, 4'b0000, -1, 0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("t4_terr_c100", {31'd0, timeout_err}, 32'd0);
        check("t4_start_c100", {31'd0, spi_start}, 32'd1);
        @(negedge clk);
        check("t4_terr_set", {31'd0, timeout_err}, 32'd1);
        check("t4_start_drop", {31'd0, spi_start}, 32'd0);
        @(posedge clk);
        #1;
        spi_en = 1'b1;
        wait_idle("t4_idle");
        push(2'b10, 1'b0, 8'h66);
        burst(1, 1, 32'h00000066, 4'b0000, -1, 0);
        wait_idle("t4_idle2");
        check("t4_terr_sticky", {31'd0, timeout_err}, 32'd1);
        do_reset();
        check("t4_terr_cleared", {31'd0, timeout_err}, 32'd0);

        // reset mid-burst on the third byte
        push(2'b10, 1'b1, 8'h11); push(2'b10, 1'b1, 8'h22);
        fork
            burst(1, 4, 32'h44332211, 4'b1111, -1, 0);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!(spi_start && spi_data == 8'h33) && k < 100);
                #1;
                rst_n = 1'b0;
                abort_burst = 1'b1;
                #1;
                check("t5_data", {24'd0, spi_data}, 32'd0);
                check("t5_comm", {31'd0, spi_comm}, 32'd0);
                check("t5_start", {31'd0, spi_start}, 32'd0);
                check("t5_grant", {30'd0, grant}, 32'd0);
                check("t5_idle", {31'd0, idle}, 32'd1);
                check("t5_r1_ready", {31'd0, r1_ready}, 32'd0);
            end
        join
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort_burst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_post_data", {24'd0, spi_data}, 32'd0);
        push(2'b10, 1'b0, 8'h77);
        burst(1, 1, 32'h00000077, 4'b0000, -1, 0);
        wait_idle("t5_idle");
        check("t5_sb_empty", exp_q.size(), 32'd0);

        // fixed priority under constant contention
        do_reset();
        q_r0_valid = 1'b1;
        q_r1_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!q_start && k < 50);
            check("fp_grant", {30'd0, q_grant}, 32'd1);
            check("fp_data", {24'd0, q_data}, 32'h21);
            @(posedge clk);
            #1;
            q_avail = 1'b1;
            @(posedge clk);
            #1;
            q_avail = 1'b0;
        end
        check("fp_r1_never_ready", {31'd0, q_r1_seen}, 32'd0);
        q_r0_valid = 1'b0;
        q_r1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
